// File: rtl/rx_gearbox_pkg.sv
// Shared PCS constants and types for the receive-side 64b/66b gearbox.
package rx_gearbox_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int HEADER_WIDTH = 2;
  localparam int BUF_SIZE     = 66;
  localparam int BLOCK_BITS   = DATA_WIDTH + HEADER_WIDTH;
  localparam int CNT_W        = 7;

  localparam logic [HEADER_WIDTH-1:0] SYNC_DATA = 2'b01;
  localparam logic [HEADER_WIDTH-1:0] SYNC_CTRL = 2'b10;

  typedef enum logic {
    HALF_FIRST  = 1'b0,
    HALF_SECOND = 1'b1
  } half_e;

endpackage

// File: rtl/rx_gearbox.sv
// Receive 64b/66b gearbox: re-frames 32-bit line words into header + two 32-bit
// data halves per block, with a one-bit slip for the block-lock logic.
module rx_gearbox
  import rx_gearbox_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_data_valid,
  input  logic                    i_slip,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [HEADER_WIDTH-1:0] o_header,
  output logic                    o_data_valid,
  output logic                    o_header_valid
);

  logic [BUF_SIZE-1:0]   buf_q;
  logic [BUF_SIZE-1:0]   buf_d;
  logic [BUF_SIZE-1:0]   bits;
  logic [BUF_SIZE-1:0]   shift_first;
  logic [BUF_SIZE-1:0]   shift_second;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [CNT_W-1:0]      n_in;
  logic [CNT_W-1:0]      total;
  logic [DATA_WIDTH-1:0] word_in;
  logic                  emit_first;
  logic                  emit_second;
  half_e                 half_q;
  half_e                 half_d;

  // A slip drops the earliest bit of the word, so only 31 bits are appended.
  assign n_in    = !i_data_valid ? CNT_W'(0) : (i_slip ? CNT_W'(DATA_WIDTH - 1) : CNT_W'(DATA_WIDTH));
  assign word_in = i_slip ? {1'b0, i_data[DATA_WIDTH-1:1]} : i_data;
  assign total   = count_q + n_in;

  // bits = held bits with this cycle's word appended just above them.
  for (genvar i = 0; i < BUF_SIZE; i++) begin : g_append
    logic [CNT_W-1:0] rel;
    assign rel     = CNT_W'(i) - count_q;
    assign bits[i] = (CNT_W'(i) < count_q) ? buf_q[i]
                   : ((rel < n_in) ? word_in[rel[4:0]] : 1'b0);
  end

  for (genvar i = 0; i < BUF_SIZE; i++) begin : g_shift
    if (i + BLOCK_BITS < BUF_SIZE) begin : g_f
      assign shift_first[i] = bits[i+BLOCK_BITS];
    end else begin : g_fz
      assign shift_first[i] = 1'b0;
    end
    if (i + DATA_WIDTH < BUF_SIZE) begin : g_s
      assign shift_second[i] = bits[i+DATA_WIDTH];
    end else begin : g_sz
      assign shift_second[i] = 1'b0;
    end
  end

  always_comb begin
    buf_d       = bits;
    count_d     = total;
    half_d      = half_q;
    emit_first  = 1'b0;
    emit_second = 1'b0;
    case (half_q)
      HALF_FIRST: begin
        if (total >= CNT_W'(BLOCK_BITS)) begin
          emit_first = 1'b1;
          buf_d      = shift_first;
          count_d    = total - CNT_W'(BLOCK_BITS);
          half_d     = HALF_SECOND;
        end
      end
      HALF_SECOND: begin
        if (total >= CNT_W'(DATA_WIDTH)) begin
          emit_second = 1'b1;
          buf_d       = shift_second;
          count_d     = total - CNT_W'(DATA_WIDTH);
          half_d      = HALF_FIRST;
        end
      end
      default: half_d = HALF_FIRST;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      buf_q   <= '0;
      count_q <= '0;
      half_q  <= HALF_FIRST;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      half_q  <= half_d;
    end
  end

  // Outputs hold their last value when nothing is emitted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data         <= '0;
      o_header       <= '0;
      o_data_valid   <= 1'b0;
      o_header_valid <= 1'b0;
    end else begin
      o_data_valid   <= emit_first | emit_second;
      o_header_valid <= emit_first;
      if (emit_first) begin
        o_header <= bits[HEADER_WIDTH-1:0];
        o_data   <= bits[BLOCK_BITS-1:HEADER_WIDTH];
      end else if (emit_second) begin
        o_data <= bits[DATA_WIDTH-1:0];
      end
    end
  end

  a_count_bound: assert property (@(posedge i_clk) disable iff (i_reset)
    count_q <= CNT_W'(BLOCK_BITS - 1));
  a_first_enough: assert property (@(posedge i_clk) disable iff (i_reset)
    emit_first |-> total >= CNT_W'(BLOCK_BITS));
  a_second_enough: assert property (@(posedge i_clk) disable iff (i_reset)
    emit_second |-> total >= CNT_W'(DATA_WIDTH));

endmodule

// File: tb/tb_rx_gearbox.sv
// Self-checking bench for rx_gearbox: directed vector table plus streamed
// 66-bit blocks checked against an expected queue.
module tb_rx_gearbox;
  import rx_gearbox_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic        i_slip = 1'b0;
  logic [31:0] o_data;
  logic [1:0]  o_header;
  logic        o_data_valid;
  logic        o_header_valid;

  always #5 i_clk = ~i_clk;

  rx_gearbox dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_data_valid   (i_data_valid),
    .i_slip         (i_slip),
    .o_data         (o_data),
    .o_header       (o_header),
    .o_data_valid   (o_data_valid),
    .o_header_valid (o_header_valid)
  );

  localparam logic [63:0] PAT_DATA = 64'h0123_4567_89AB_CDEF;

  typedef struct {
    logic        v;
    logic        s;
    logic [31:0] d;
    logic        dv;
    logic        hv;
    logic [1:0]  hdr;
    logic [31:0] data;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        line_q[$];
  logic [34:0] exp_q[$];
  int          sb_mode = 0;    // 0 off, 1 exact expected queue, 2 pattern match
  int          skip_left = 0;
  int          pat_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_block(input logic [1:0] hdr, input logic [63:0] data, input bit expect_it);
    for (int k = 0; k < 2; k++) line_q.push_back(hdr[k]);
    for (int k = 0; k < 64; k++) line_q.push_back(data[k]);
    if (expect_it) begin
      exp_q.push_back({1'b1, hdr, data[31:0]});
      exp_q.push_back({1'b0, 2'b00, data[63:32]});
    end
  endtask

  task automatic pad_line();
    while ((line_q.size() % 32) != 0) line_q.push_back(1'b0);
  endtask

  task automatic scoreboard();
    logic [34:0] e;
    if (!o_data_valid) return;
    if (sb_mode == 1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got data %0h hv %0b with nothing expected", o_data, o_header_valid);
      end else begin
        e = exp_q.pop_front();
        check("sb_hv", 64'(o_header_valid), 64'(e[34]));
        check("sb_data", 64'(o_data), 64'(e[31:0]));
        if (e[34]) check("sb_hdr", 64'(o_header), 64'(e[33:32]));
      end
    end else if (sb_mode == 2) begin
      if (skip_left > 0) begin
        skip_left--;
      end else begin
        pat_seen++;
        if (o_header_valid) begin
          check("pat_hdr_sync", 64'(o_header == SYNC_DATA || o_header == SYNC_CTRL), 64'd1);
          check("pat_data_lo", 64'(o_data), 64'(PAT_DATA[31:0]));
        end else begin
          check("pat_data_hi", 64'(o_data), 64'(PAT_DATA[63:32]));
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [31:0] d);
    i_data_valid = v;
    i_slip       = s;
    i_data       = d;
    @(posedge i_clk);
    #1;
    scoreboard();
  endtask

  task automatic feed(input logic s);
    logic [31:0] w;
    w = '0;
    if (line_q.size() >= 32) begin
      for (int k = 0; k < 32; k++) w[k] = line_q.pop_front();
      step(1'b1, s, w);
    end else begin
      step(1'b0, s, w);
    end
  endtask

  task automatic do_reset();
    i_data_valid = 1'b0;
    i_slip       = 1'b0;
    i_data       = '0;
    i_reset      = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    line_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[9];

  initial begin
    int wi;
    int gap_cnt;
    int last_gap;

    vecs[0] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'b00, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 2'b11, 32'h3FFF_FFFF};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 2'b11, 32'h3FFF_FFFF};
    vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'b11, 32'hC000_0000};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 2'b11, 32'h0FFF_FFFF};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'b11, 32'hF800_0000};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 2'b11, 32'h00FF_FFFF};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 2'b11, 32'h00FF_FFFF};
    vecs[8] = '{1'b1, 1'b0, 32'hA5A5_A5A5, 1'b1, 1'b0, 2'b11, 32'hA500_0000};

    // Reset state and directed vector table
    do_reset();
    check("reset_state", 64'({o_data_valid, o_header_valid, o_header, o_data}), 64'd0);
    sb_mode = 0;
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v, vecs[i].s, vecs[i].d);
      check($sformatf("vec%0d", i), 64'({o_data_valid, o_header_valid, o_header, o_data}),
            64'({vecs[i].dv, vecs[i].hv, vecs[i].hdr, vecs[i].data}));
    end

    // 66 pattern blocks, with an input stall and an idle-cycle slip mid-stream
    do_reset();
    sb_mode = 1;
    for (int b = 0; b < 66; b++) push_block(SYNC_DATA, PAT_DATA, 1'b1);
    pad_line();
    wi = 0;
    while (line_q.size() > 0) begin
      if (wi == 40) begin
        for (int k = 0; k < 3; k++) begin
          step(1'b0, 1'b0, $urandom);
          check("stall_dv", 64'(o_data_valid), 64'd0);
        end
      end
      if (wi == 90) step(1'b0, 1'b1, $urandom);
      feed(1'b0);
      wi++;
    end
    repeat (2) step(1'b0, 1'b0, 32'h0);
    check("exp_drained", 64'(exp_q.size()), 64'd0);

    // Continuous input: one idle output cycle every 33
    do_reset();
    sb_mode  = 0;
    gap_cnt  = 0;
    last_gap = -1;
    for (int c = 1; c <= 330; c++) begin
      step(1'b1, 1'b0, $urandom);
      if (!o_data_valid) begin
        gap_cnt++;
        if (last_gap < 0) check("first_gap", 64'(c), 64'd1);
        else check("gap_spacing", 64'(c - last_gap), 64'd33);
        last_gap = c;
      end
    end
    check("gap_count", 64'(gap_cnt), 64'd10);

    // Stream offset by 5 bits, realigned with 5 slips
    do_reset();
    sb_mode   = 2;
    skip_left = 14;
    pat_seen  = 0;
    line_q.push_back(1'b1);
    line_q.push_back(1'b1);
    line_q.push_back(1'b0);
    line_q.push_back(1'b1);
    line_q.push_back(1'b0);
    for (int b = 0; b < 40; b++) push_block(SYNC_DATA, PAT_DATA, 1'b0);
    pad_line();
    wi = 0;
    while (line_q.size() > 0) begin
      feed((wi >= 2 && wi <= 10 && (wi % 2) == 0) ? 1'b1 : 1'b0);
      wi++;
    end
    repeat (2) step(1'b0, 1'b0, 32'h0);
    check("pat_outputs", 64'(pat_seen), 64'd66);

    // Asynchronous reset mid-block
    do_reset();
    sb_mode = 1;
    for (int b = 0; b < 10; b++) push_block(SYNC_CTRL, PAT_DATA, 1'b1);
    for (int k = 0; k < 8; k++) feed(1'b0);
    check("pre_reset_dv", 64'(o_data_valid), 64'd1);
    #2;
    i_data_valid = 1'b0;
    i_reset      = 1'b1;
    #1;
    check("async_reset_outputs", 64'({o_data_valid, o_header_valid, o_header, o_data}), 64'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    line_q.delete();
    exp_q.delete();
    sb_mode = 0;
    for (int b = 0; b < 2; b++) push_block(SYNC_DATA, PAT_DATA, 1'b0);
    feed(1'b0);
    check("post_reset_c1", 64'({o_data_valid, o_header_valid}), 64'd0);
    feed(1'b0);
    check("post_reset_c2", 64'({o_data_valid, o_header_valid, o_header, o_data}),
          64'({1'b1, 1'b1, SYNC_DATA, PAT_DATA[31:0]}));
    feed(1'b0);
    check("post_reset_c3", 64'({o_data_valid, o_header_valid, o_data}),
          64'({1'b1, 1'b0, PAT_DATA[63:32]}));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
